uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Oversampling UART receiver. Each frame is: start bit (0), 8 data bits LSB
//   first, an optional parity bit, then one stop bit (1). Every bit lasts
//   PRESCALE clocks. A bit's value is the 2-of-3 majority of the synchronized
//   line, sampled around the middle of the bit. The outcome of a frame is
//   reported by exactly one registered one-cycle pulse, or by STP_ERR and
//   PAR_ERR together.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   RX_IN      : serial line, idle high (asynchronous to clk)
//   PRESCALE   : clocks per bit (8, 16 or 32; any other value acts as 8)
//   PAR_EN     : 1 = a parity bit follows the data bits
//   PAR_TYP    : 1 = parity bit equals XOR of the data, 0 = its inverse
//   P_DATA     : last good received byte (updates only with DATA_VALID)
//   DATA_VALID : one-cycle pulse, good frame received
//   PAR_ERR    : one-cycle pulse, parity mismatch
//   STP_ERR    : one-cycle pulse, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    // Unsupported oversampling ratios fall back to 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            6'd8, 6'd16, 6'd32: return p;
            default:            return 6'd8;
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t                state;
    state_t                next_state;

    logic                  rx_meta;
    logic                  rx_sync;

    logic [5:0]            presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;

    logic [5:0]            edge_cnt;
    logic [3:0]            bit_cnt;
    logic [5:0]            half;

    logic                  samp_a;
    logic                  samp_b;
    logic                  bit_val;
    logic                  par_fail;
    logic                  exp_par;
    logic [DATA_WIDTH-1:0] shift_reg;

    logic                  frame_start;
    logic                  last_edge;
    logic                  data_done;
    logic                  dv_d;
    logic                  pe_d;
    logic                  se_d;

    assign half        = presc_q >> 1;
    assign last_edge   = (edge_cnt == presc_q - 6'd1);
    assign frame_start = (state == IDLE) && !rx_sync;
    assign data_done   = last_edge && (bit_cnt == 4'(DATA_WIDTH - 1));
    assign exp_par     = par_typ_q ? ^shift_reg : ~^shift_reg;

    // Two-flop synchronizer; flops reset to the idle level so that reset
    // release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    next_state = START;
                end
            end
            START: begin
                // A start bit that votes high was a glitch: drop it silently.
                if (last_edge) begin
                    next_state = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (data_done) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    if (bit_val) begin
                        // Back to IDLE right away so a back-to-back start bit
                        // is seen on the very next clock.
                        pe_d       = par_fail;
                        dv_d       = !par_fail;
                        next_state = IDLE;
                    end else begin
                        // Low stop bit: report once, then wait for the line to
                        // go high so a break yields a single error.
                        se_d       = 1'b1;
                        pe_d       = par_fail;
                        next_state = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame timing, bit voting, captured configuration and result pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= 6'd8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            edge_cnt   <= 6'd0;
            bit_cnt    <= 4'd0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            bit_val    <= 1'b1;
            par_fail   <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= dv_d;
            PAR_ERR    <= pe_d;
            STP_ERR    <= se_d;
            if (dv_d) begin
                P_DATA <= shift_reg;
            end

            if (frame_start) begin
                // Configuration is frozen for the whole frame from here on.
                presc_q   <= legal_prescale(PRESCALE);
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                edge_cnt  <= 6'd0;
                bit_cnt   <= 4'd0;
                par_fail  <= 1'b0;
            end else if (state == IDLE || state == WAIT_IDLE) begin
                edge_cnt <= 6'd0;
            end else begin
                edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;

                if (edge_cnt == half - 6'd1) begin
                    samp_a <= rx_sync;
                end
                if (edge_cnt == half) begin
                    samp_b <= rx_sync;
                end
                if (edge_cnt == half + 6'd1) begin
                    bit_val <= majority3(samp_a, samp_b, rx_sync);
                end

                if (state == DATA && last_edge) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (state == PARITY && last_edge) begin
                    par_fail <= (bit_val != exp_par);
                end
            end
        end
    end

    // Payload shifter; its content only matters once a full byte is in.
    always_ff @(posedge clk) begin
        if (state == DATA && last_edge) begin
            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Drives serial frames onto RX_IN, queues the expected outcome of every frame
//   (pulse kind, byte, cycle of appearance) and lets an independent monitor
//   compare each DUT result pulse against the head of the queue.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] model_pdata = 8'h00;
    logic [7:0] prev_pdata  = 8'h00;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .RX_IN     (RX_IN),
        .PRESCALE  (PRESCALE),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR   (PAR_ERR),
        .STP_ERR   (STP_ERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int eff_prescale(input logic [5:0] p);
        if (p == 6'd8 || p == 6'd16 || p == 6'd32) return int'(p);
        return 8;
    endfunction

    // Parity bit a transmitter puts on the line for this byte.
    function automatic logic parity_bit(input logic [7:0] d, input logic typ);
        logic odd;
        odd = ($countones(d) % 2) != 0;
        return typ ? odd : !odd;
    endfunction

    // Sends one frame. Line changes happen 1 time unit after edge E; the DUT
    // sees the start bit at E+3 (two synchronizer flops plus the FSM edge),
    // so the result is due in cycle E+3+N*P.
    task automatic send_frame(input logic [7:0] data, input logic [5:0] pre,
                              input logic pen, input logic ptyp,
                              input logic flip_par, input logic stop_val,
                              input int hold_low, input int gap,
                              input int reset_bit, input logic garble);
        int   p;
        int   n;
        int   e;
        logic bits[$];
        exp_t x;
        p = eff_prescale(pre);
        n = pen ? 11 : 10;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(parity_bit(data, ptyp) ^ flip_par);
        bits.push_back(stop_val);

        PRESCALE = pre;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        e = cyc;
        if (reset_bit < 0) begin
            x.pe   = pen && flip_par;
            x.se   = !stop_val;
            x.dv   = stop_val && !x.pe;
            x.data = data;
            x.at   = e + 3 + n * p;
            exp_q.push_back(x);
        end

        for (int k = 0; k < bits.size(); k++) begin
            RX_IN = bits[k];
            for (int j = 0; j < p; j++) begin
                if (garble && k == 1 && j == 0) begin
                    PRESCALE = 6'($urandom);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
                if (k == reset_bit && j == p / 2) begin
                    reset = 1'b0;
                    #1;
                    check("reset_mid_p_data", 32'(P_DATA), 32'h0);
                    check("reset_mid_pulses", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
                end
                tick(1);
            end
        end
        if (!stop_val) tick(hold_low);
        RX_IN = 1'b1;
        if (reset_bit >= 0) begin
            tick(2);
            reset = 1'b1;
        end
        tick(gap);
    endtask

    // Monitor: every result pulse must match the oldest queued expectation,
    // at the predicted cycle; P_DATA may only change to the modelled value.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!reset) model_pdata = 8'h00;
            if (DATA_VALID || PAR_ERR || STP_ERR) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
                end else begin
                    x = exp_q.pop_front();
                    check("pulse_flags_dv_pe_se", 32'({DATA_VALID, PAR_ERR, STP_ERR}),
                          32'({x.dv, x.pe, x.se}));
                    check("pulse_cycle", 32'(cyc), 32'(x.at));
                    if (x.dv) begin
                        check("p_data", 32'(P_DATA), 32'(x.data));
                        model_pdata = x.data;
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
                x = exp_q.pop_front();
                check("missing_pulse_dv_pe_se", 32'({DATA_VALID, PAR_ERR, STP_ERR}),
                      32'({x.dv, x.pe, x.se}));
            end
            if (P_DATA !== prev_pdata) check("p_data_hold", 32'(P_DATA), 32'(model_pdata));
            prev_pdata = P_DATA;
        end
    end

    initial begin
        logic [5:0] ptab [6];
        logic [5:0] pre;
        logic       stopv;
        int         guard;
        ptab = '{6'd8, 6'd16, 6'd32, 6'd0, 6'd12, 6'd63};

        reset    = 1'b0;
        RX_IN    = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        tick(3);
        check("reset_p_data", 32'(P_DATA), 32'h0);
        check("reset_data_valid", 32'(DATA_VALID), 32'h0);
        check("reset_par_err", 32'(PAR_ERR), 32'h0);
        check("reset_stp_err", 32'(STP_ERR), 32'h0);
        reset = 1'b1;
        tick(5);

        // Plain 8N1 frame.
        send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, -1, 1'b0);
        // Even-type parity, wrong parity bit: PAR_ERR only, byte not loaded.
        send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4, -1, 1'b0);
        // Stop bit low then a long break: one STP_ERR, then recovery.
        send_frame(8'hC3, 6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 100, 4, -1, 1'b0);
        send_frame(8'h5A, 6'd32, 1'b1, 1'b0, 1'b0, 1'b1, 0, 4, -1, 1'b0);

        // Short low glitches are rejected; the following frame still decodes.
        for (int i = 0; i < 3; i++) begin
            int p;
            p = 8 << i;
            PRESCALE = 6'(p);
            RX_IN = 1'b0;
            tick(p / 2 - 2);
            RX_IN = 1'b1;
            tick(3 * p);
            send_frame(8'hFF, 6'(p), 1'($urandom), 1'($urandom), 1'b0, 1'b1, 0, 4, -1, 1'b0);
        end

        // Reset during data bit 4 (frame bit 5) kills the frame.
        send_frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, 5, 1'b0);
        send_frame(8'h7E, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, -1, 1'b0);

        // Near back-to-back random good frames, config inputs garbled mid-frame.
        for (int i = 0; i < 400; i++) begin
            send_frame(8'($urandom), 6'd8, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 0,
                       1 + $urandom_range(0, 1), -1, 1'b1);
        end

        // Random prescale (including unsupported values), parity and errors.
        for (int i = 0; i < 100; i++) begin
            pre   = ptab[$urandom_range(0, 5)];
            stopv = ($urandom_range(0, 7) != 0);
            send_frame(8'($urandom), pre, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) == 0), stopv,
                       stopv ? 0 : $urandom_range(0, 40), 2 + $urandom_range(0, 3), -1, 1'b1);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            tick(1);
            guard++;
        end
        tick(4);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
